// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e          kind;
    logic [CODE_W-1:0]   code;
  } scan_res_t;

  localparam logic [COL_W-1:0] COL_PAT_0 = 4'b1110;
  localparam logic [COL_W-1:0] COL_PAT_1 = 4'b1101;
  localparam logic [COL_W-1:0] COL_PAT_2 = 4'b1011;
  localparam logic [COL_W-1:0] COL_PAT_3 = 4'b0111;

  // Active-low drive pattern for a column index.
  function automatic logic [COL_W-1:0] col_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return COL_PAT_0;
      2'd1:    return COL_PAT_1;
      2'd2:    return COL_PAT_2;
      default: return COL_PAT_3;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones (idle pulled-up rows).
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, per-scan classification and
// press/release debounce producing a one-cycle key_valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [ROW_W-1:0]  IO_P4_ROW,
  output logic [COL_W-1:0]  IO_P4_COL,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_down
);

  localparam int unsigned SLOT_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DB_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic [ROW_W-1:0]  row_s;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic [1:0]        acc_cnt;
  logic [CODE_W-1:0] acc_code;
  logic              scan_done;
  scan_res_t         scan_res;

  sync_2ff #(.WIDTH(ROW_W)) u_row_sync (
    .Clk   (Clk),
    .reset (reset),
    .d     (IO_P4_ROW),
    .q     (row_s)
  );

  // Classify the current column's rows and fold them into the scan tally.
  logic              slot_end_c;
  logic [2:0]        low_cnt_c;
  logic [1:0]        low_row_c;
  logic [2:0]        total_c;
  logic [1:0]        acc_cnt_c;
  logic [CODE_W-1:0] acc_code_c;

  always_comb begin
    slot_end_c = (slot_cnt == SLOT_LAST);
    low_cnt_c  = '0;
    low_row_c  = '0;
    for (int r = 0; r < ROW_W; r++) begin
      if (!row_s[2'(r)]) begin
        low_cnt_c = low_cnt_c + 3'd1;
        low_row_c = 2'(r);
      end
    end
    total_c    = {1'b0, acc_cnt} + low_cnt_c;
    acc_cnt_c  = (total_c >= 3'd2) ? 2'd2 : total_c[1:0];
    acc_code_c = (low_cnt_c == 3'd1) ? {low_row_c, col_idx} : acc_code;
  end

  // Column strobe, row sampling on the last cycle of each slot.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      col_idx   <= '0;
      IO_P4_COL <= COL_PAT_0;
      acc_cnt   <= '0;
      acc_code  <= '0;
      scan_done <= 1'b0;
      scan_res  <= '{kind: SCAN_NONE, code: '0};
    end else begin
      scan_done <= 1'b0;
      if (slot_end_c) begin
        slot_cnt  <= '0;
        col_idx   <= col_idx + 2'd1;
        IO_P4_COL <= col_pattern(col_idx + 2'd1);
        if (col_idx == 2'd3) begin
          acc_cnt       <= '0;
          acc_code      <= '0;
          scan_done     <= 1'b1;
          scan_res.code <= acc_code_c;
          case (acc_cnt_c)
            2'd0:    scan_res.kind <= SCAN_NONE;
            2'd1:    scan_res.kind <= SCAN_SINGLE;
            default: scan_res.kind <= SCAN_MULTI;
          endcase
        end else begin
          acc_cnt  <= acc_cnt_c;
          acc_code <= acc_code_c;
        end
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  kp_state_e         state, state_d;
  logic [CODE_W-1:0] cand, cand_d;
  logic [CNT_W-1:0]  db_cnt, cnt_d;
  logic [CODE_W-1:0] code_d;
  logic              valid_d;
  logic              down_d;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cand      <= '0;
      db_cnt    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_d;
      cand      <= cand_d;
      db_cnt    <= cnt_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_down  <= down_d;
    end
  end

  // Debounce FSM, advanced once per completed scan; MULTI counts as NONE.
  logic             single_c;
  logic [CNT_W-1:0] cnt_inc_c;

  always_comb begin
    state_d   = state;
    cand_d    = cand;
    cnt_d     = db_cnt;
    code_d    = key_code;
    valid_d   = 1'b0;
    single_c  = (scan_res.kind == SCAN_SINGLE);
    cnt_inc_c = db_cnt + CNT_W'(1);
    if (scan_done) begin
      case (state)
        ST_IDLE: begin
          if (single_c) begin
            cand_d = scan_res.code;
            if (DB_TARGET == CNT_W'(1)) begin
              state_d = ST_HELD;
              code_d  = scan_res.code;
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!single_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (scan_res.code == cand) begin
            if (cnt_inc_c >= DB_TARGET) begin
              state_d = ST_HELD;
              code_d  = cand;
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            cand_d = scan_res.code;
            cnt_d  = CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!single_c) begin
            if (DB_TARGET == CNT_W'(1)) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (!single_c) begin
            if (cnt_inc_c >= DB_TARGET) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else if (scan_res.code == key_code) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    down_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

endmodule
